tile_match_ctrl: RTL and testbench
==================================

Name: tile_match_ctrl

Overview:
Game-side sequencer for the 16-entry tile colour RAM. Accepts player selections (cursor index plus select pulse) and reads each chosen tile's colour through RAM port A. It compares each pair, marks matched tiles and overwrites them with MATCH_COLOR, and hides mismatched pairs after a display delay. It drives the revealed/matched masks, move counter and game-over flag consumed by the VGA overlay and score display.

Parameters:
SHOW_TICKS, 24'd12_500_000, gameClk cycles a mismatched pair stays revealed before hiding (minimum 1)
INIT_WAIT, 5'd18, cycles after reset release before selects are accepted; covers the RAM's 16-cycle reload
MATCH_COLOR, 8'hFF, colour written to both tiles of a matched pair
NUM_PAIRS, 4'd8, pairs needed for game over

Ports:
gameClk  in  1  game clock; all logic on posedge
resetn  in  1  asynchronous, active-high reset; also drives the RAM's reload
sel  in  1  one-cycle select pulse, already debounced
cursor  in  4  tile index being selected
ramAddr  out  4  RAM port A address, registered
ramWrite  out  8  RAM port A write data, registered
ramWe  out  1  RAM port A write enable, registered
ramRead  in  8  RAM port A read data; valid 2 edges after ramAddr changes
revealed  out  16  bit i = tile i face-up (includes matched tiles)
matched  out  16  bit i = tile i permanently matched
pairs  out  4  matched pair count
moves  out  8  completed pair attempts, saturating at 255
gameOver  out  1  high while pairs == NUM_PAIRS
busy  out  1  high in every state except IDLE1/IDLE2

Behaviour:
- Reset (async, resetn=1): state=INIT; all outputs 0 (ramAddr, ramWrite, ramWe, masks, pairs, moves, gameOver); busy=1; init counter=0.
- INIT: count INIT_WAIT cycles after resetn falls, then go to IDLE1. sel is ignored.
- IDLE1: on sel with revealed[cursor]=0: latch idx1=cursor, ramAddr<=cursor, go to RD1. A sel on a revealed/matched tile is ignored, with no move counted.
- RD1: one wait cycle (RAM samples the address) -> CAP1.
- CAP1: col1<=ramRead; revealed[idx1]<=1 -> IDLE2.
- IDLE2: on sel with revealed[cursor]=0 (excludes idx1): latch idx2, ramAddr<=cursor -> RD2. Otherwise ignored.
- RD2 -> CAP2: col2<=ramRead; revealed[idx2]<=1; moves<=moves+1 (saturating) -> CMP.
- CMP: if col1==col2 -> WR1, else HOLD with timer loaded to SHOW_TICKS.
- WR1: ramAddr<=idx1, ramWrite<=MATCH_COLOR, ramWe<=1; matched[idx1], matched[idx2]<=1 -> WR2.
- WR2: ramAddr<=idx2 (ramWe stays 1) -> WREND.
- WREND: ramWe<=0; pairs<=pairs+1; go to DONE if the new count equals NUM_PAIRS, else IDLE1.
- HOLD: decrement timer. At 0: clear revealed[idx1] and revealed[idx2] -> IDLE1.
- DONE: gameOver=1; sel ignored; exit only via reset.
- ramWe is high for exactly 2 consecutive cycles per match and never otherwise.
- sel during any busy state is dropped, not queued.
- A cursor change between sel pulses has no effect; only the value at the sel cycle matters.
- Reset mid-operation (including during HOLD or WR1/WR2) aborts immediately. RAM contents are restored by the RAM's own reload.
- The colour comparison is a full 8-bit equality test.
- The masks and counters come directly from registers; no combinational paths from inputs to outputs.

Decomposition:
- Shared package tile_pkg: state encoding (INIT, IDLE1, RD1, CAP1, IDLE2, RD2, CAP2, CMP, WR1, WR2, WREND, HOLD, DONE), NUM_TILES=16, MATCH_COLOR default, initial colour constants shared with the RAM's reload table.
- One sub-module: hold_timer (load, enable, expired). It is a loadable down-counter of width $clog2(SHOW_TICKS+1).

Test Plan:
- Reset release -> busy=1 for 18 cycles. A sel pulse at cycle 5 is ignored; the controller reaches IDLE1 with all outputs 0.
- Select tile 2, then tile 3 (both 8'hE0):
  - revealed=16'h000C, moves=1.
  - ramWe high for 2 cycles at addrs 2 then 3, data 8'hFF.
  - matched=16'h000C, pairs=1.
- Select 0 (8'h3C), then 1 (8'hC8), SHOW_TICKS=4:
  - revealed=16'h0003 for 4 cycles, then 16'h0000.
  - moves=1, ramWe never asserted.
- Select 0, then 0 again; then sel on already-matched tile 2 -> both ignored, state IDLE2/IDLE1 unchanged, moves unchanged.
- Complete all 8 pairs -> pairs=8, gameOver=1, matched=16'hFFFF. Further sel pulses have no effect.
- Assert resetn during HOLD and during WR2 -> all outputs 0 in the same cycle (async), INIT restarts, and the next game behaves normally.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared definitions for the tile matching game: sequencer states, board size,
// and the power-on colour layout that the colour RAM reloads on reset.
package tile_pkg;

    localparam int NUM_TILES = 16;
    localparam int IDX_W = $clog2(NUM_TILES);
    localparam logic [7:0] MATCH_COLOR_DEFAULT = 8'hFF;

    typedef enum logic [3:0] {
        INIT, IDLE1, RD1, CAP1, IDLE2, RD2, CAP2, CMP, WR1, WR2, WREND, HOLD, DONE
    } state_t;

    // Every colour appears on exactly two tiles and none equals MATCH_COLOR.
    function automatic logic [7:0] init_color(input logic [IDX_W-1:0] idx);
        logic [7:0] color;
        case (idx)
            4'd0, 4'd4:   color = 8'h3C;
            4'd1, 4'd5:   color = 8'hC8;
            4'd2, 4'd3:   color = 8'hE0;
            4'd6, 4'd7:   color = 8'h1F;
            4'd8, 4'd9:   color = 8'hA5;
            4'd10, 4'd11: color = 8'h07;
            4'd12, 4'd13: color = 8'h5A;
            default:      color = 8'hF0;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times how long a mismatched pair stays face-up.
module hold_timer #(
    parameter logic [23:0] SHOW_TICKS = 24'd12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(SHOW_TICKS + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= SHOW_TICKS[W-1:0];
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Flags the tick that takes the count to zero, so a load of N gives N enabled cycles.
    assign expired = (count <= W'(1));

endmodule

// File: rtl/tile_match_ctrl.sv
// Game sequencer: reads two selected tiles from the colour RAM, compares them,
// marks and overwrites matches, and hides mismatched pairs after a delay.
module tile_match_ctrl
    import tile_pkg::*;
#(
    parameter logic [23:0] SHOW_TICKS  = 24'd12_500_000,
    parameter logic [4:0]  INIT_WAIT   = 5'd18,
    parameter logic [7:0]  MATCH_COLOR = MATCH_COLOR_DEFAULT,
    parameter logic [3:0]  NUM_PAIRS   = 4'd8
) (
    input  logic                 gameClk,
    input  logic                 resetn,
    input  logic                 sel,
    input  logic [IDX_W-1:0]     cursor,
    output logic [IDX_W-1:0]     ramAddr,
    output logic [7:0]           ramWrite,
    output logic                 ramWe,
    input  logic [7:0]           ramRead,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [3:0]           pairs,
    output logic [7:0]           moves,
    output logic                 gameOver,
    output logic                 busy
);

    state_t state, state_next;

    logic [4:0]       init_count;
    logic [IDX_W-1:0] idx1, idx2;
    logic [7:0]       col1, col2;
    logic             accept;
    logic             take1, take2, cap1, cap2, wr1, wr2, wrend, hide;
    logic             timer_load, timer_en, timer_expired;

    assign accept = sel && !revealed[cursor];

    hold_timer #(
        .SHOW_TICKS(SHOW_TICKS)
    ) u_hold_timer (
        .clk    (gameClk),
        .rst    (resetn),
        .load   (timer_load),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge gameClk or posedge resetn) begin
        if (resetn) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take1      = 1'b0;
        take2      = 1'b0;
        cap1       = 1'b0;
        cap2       = 1'b0;
        wr1        = 1'b0;
        wr2        = 1'b0;
        wrend      = 1'b0;
        hide       = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            INIT:  if (init_count == INIT_WAIT - 5'd1) state_next = IDLE1;
            IDLE1: if (accept) begin take1 = 1'b1; state_next = RD1; end
            RD1:   state_next = CAP1;
            CAP1:  begin cap1 = 1'b1; state_next = IDLE2; end
            IDLE2: if (accept) begin take2 = 1'b1; state_next = RD2; end
            RD2:   state_next = CAP2;
            CAP2:  begin cap2 = 1'b1; state_next = CMP; end
            CMP: begin
                if (col1 == col2) begin
                    state_next = WR1;
                end else begin
                    timer_load = 1'b1;
                    state_next = HOLD;
                end
            end
            WR1:   begin wr1 = 1'b1; state_next = WR2; end
            WR2:   begin wr2 = 1'b1; state_next = WREND; end
            WREND: begin
                wrend      = 1'b1;
                state_next = (pairs + 4'd1 == NUM_PAIRS) ? DONE : IDLE1;
            end
            HOLD: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    hide       = 1'b1;
                    state_next = IDLE1;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = INIT;
        endcase
    end

    // Datapath registers; the FSM strobes above decide which of them move each cycle.
    always_ff @(posedge gameClk or posedge resetn) begin
        if (resetn) begin
            init_count <= '0;
            idx1       <= '0;
            idx2       <= '0;
            col1       <= '0;
            col2       <= '0;
            ramAddr    <= '0;
            ramWrite   <= '0;
            ramWe      <= 1'b0;
            revealed   <= '0;
            matched    <= '0;
            pairs      <= '0;
            moves      <= '0;
        end else begin
            if (state == INIT) init_count <= init_count + 5'd1;
            if (take1) begin
                idx1    <= cursor;
                ramAddr <= cursor;
            end
            if (take2) begin
                idx2    <= cursor;
                ramAddr <= cursor;
            end
            if (cap1) begin
                col1           <= ramRead;
                revealed[idx1] <= 1'b1;
            end
            if (cap2) begin
                col2           <= ramRead;
                revealed[idx2] <= 1'b1;
                if (moves != 8'hFF) moves <= moves + 8'd1;
            end
            if (wr1) begin
                ramAddr       <= idx1;
                ramWrite      <= MATCH_COLOR;
                ramWe         <= 1'b1;
                matched[idx1] <= 1'b1;
                matched[idx2] <= 1'b1;
            end
            if (wr2) ramAddr <= idx2;
            if (wrend) begin
                ramWe <= 1'b0;
                pairs <= pairs + 4'd1;
            end
            if (hide) begin
                revealed[idx1] <= 1'b0;
                revealed[idx2] <= 1'b0;
            end
        end
    end

    assign gameOver = (pairs == NUM_PAIRS);
    assign busy     = (state != IDLE1) && (state != IDLE2);

endmodule

// File: tb/tb_tile_match_ctrl.sv
// Bench for tile_match_ctrl: a colour RAM model, an event-scheduled game model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_tile_match_ctrl;

    localparam logic [23:0] SHOW = 24'd4;
    localparam int          WAIT_CYCLES = 18;

    logic        gameClk = 1'b0;
    logic        resetn  = 1'b1;
    logic        sel     = 1'b0;
    logic [3:0]  cursor  = 4'd0;
    logic [3:0]  ramAddr;
    logic [7:0]  ramWrite;
    logic        ramWe;
    logic [7:0]  ramRead;
    logic [15:0] revealed;
    logic [15:0] matched;
    logic [3:0]  pairs;
    logic [7:0]  moves;
    logic        gameOver;
    logic        busy;

    tile_match_ctrl #(
        .SHOW_TICKS (SHOW),
        .INIT_WAIT  (5'd18),
        .MATCH_COLOR(8'hFF),
        .NUM_PAIRS  (4'd8)
    ) dut (
        .gameClk (gameClk),
        .resetn  (resetn),
        .sel     (sel),
        .cursor  (cursor),
        .ramAddr (ramAddr),
        .ramWrite(ramWrite),
        .ramWe   (ramWe),
        .ramRead (ramRead),
        .revealed(revealed),
        .matched (matched),
        .pairs   (pairs),
        .moves   (moves),
        .gameOver(gameOver),
        .busy    (busy)
    );

    always #5 gameClk = ~gameClk;

    logic [7:0] colors [16] = '{8'h3C, 8'hC8, 8'hE0, 8'hE0, 8'h3C, 8'hC8, 8'h1F, 8'h1F,
                                8'hA5, 8'hA5, 8'h07, 8'h07, 8'h5A, 8'h5A, 8'hF0, 8'hF0};
    logic [7:0] mem [16];

    // Colour RAM: one-cycle registered read, reloaded while reset is high.
    always @(posedge gameClk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= colors[i];
            ramRead <= 8'h00;
        end else begin
            if (ramWe) mem[ramAddr] <= ramWrite;
            ramRead <= mem[ramAddr];
        end
    end

    int          n_vec = 0;
    int          n_bad = 0;
    logic [3:0]  we_log [$];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Game model: each accepted pick schedules its visible consequences at fixed latencies.
    int          cyc;
    bit          m_busy, m_init, m_have_first, accept;
    int          m_first, m_second, m_pairs, m_moves;
    logic [15:0] m_rev, m_mat;
    bit          m_we;
    logic [3:0]  m_waddr;
    int          t_rev1, t_rev2, t_wr1, t_wr2, t_wrend, t_hide;

    always @(posedge gameClk or posedge resetn) begin
        if (resetn) begin
            cyc = 0; m_busy = 1; m_init = 1; m_have_first = 0;
            m_first = 0; m_second = 0; m_pairs = 0; m_moves = 0;
            m_rev = '0; m_mat = '0; m_we = 0; m_waddr = '0;
            t_rev1 = -1; t_rev2 = -1; t_wr1 = -1; t_wr2 = -1; t_wrend = -1; t_hide = -1;
        end else begin
            accept = !m_busy && sel && !m_rev[cursor];
            cyc++;
            if (m_init && cyc == WAIT_CYCLES) begin m_init = 0; m_busy = 0; end
            if (cyc == t_rev1) begin m_rev[m_first] = 1'b1; m_busy = 0; end
            if (cyc == t_rev2) begin
                m_rev[m_second] = 1'b1;
                if (m_moves < 255) m_moves++;
            end
            if (cyc == t_wr1) begin
                m_mat[m_first] = 1'b1; m_mat[m_second] = 1'b1;
                m_we = 1; m_waddr = 4'(m_first);
            end
            if (cyc == t_wr2) m_waddr = 4'(m_second);
            if (cyc == t_wrend) begin
                m_we = 0; m_pairs++;
                if (m_pairs != 8) m_busy = 0;
            end
            if (cyc == t_hide) begin
                m_rev[m_first] = 1'b0; m_rev[m_second] = 1'b0; m_busy = 0;
            end
            if (accept) begin
                m_busy = 1;
                if (!m_have_first) begin
                    m_first = int'(cursor); m_have_first = 1; t_rev1 = cyc + 2;
                end else begin
                    m_second = int'(cursor); m_have_first = 0; t_rev2 = cyc + 2;
                    if (colors[m_first] == colors[m_second]) begin
                        t_wr1 = cyc + 4; t_wr2 = cyc + 5; t_wrend = cyc + 6;
                    end else begin
                        t_hide = cyc + 3 + int'(SHOW);
                    end
                end
            end
        end
    end

    always @(negedge gameClk) begin
        check_output("busy", 32'(busy), 32'(m_busy));
        check_output("revealed", 32'(revealed), 32'(m_rev));
        check_output("matched", 32'(matched), 32'(m_mat));
        check_output("pairs", 32'(pairs), m_pairs);
        check_output("moves", 32'(moves), m_moves);
        check_output("gameOver", 32'(gameOver), 32'(m_pairs == 8));
        check_output("ramWe", 32'(ramWe), 32'(m_we));
        if (m_we) begin
            check_output("ramAddr", 32'(ramAddr), 32'(m_waddr));
            check_output("ramWrite", 32'(ramWrite), 32'h0000_00FF);
        end
        if (ramWe) we_log.push_back(ramAddr);
    end

    task automatic apply_stimulus(input logic [3:0] idx);
        @(negedge gameClk);
        sel    = 1'b1;
        cursor = idx;
        @(negedge gameClk);
        sel    = 1'b0;
        cursor = 4'($urandom_range(15, 0));
    endtask

    task automatic wait_settle(input string name);
        int k = 0;
        while (busy && !gameOver && k < 200) begin
            @(negedge gameClk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL %s: timeout waiting for idle, busy=%0b", name, busy);
        end
    endtask

    task automatic play_pair(input logic [3:0] a, input logic [3:0] b);
        apply_stimulus(a);
        wait_settle("pick_a");
        apply_stimulus(b);
        wait_settle("pick_b");
    endtask

    task automatic release_and_init();
        @(negedge gameClk);
        resetn = 1'b0;
        for (int i = 1; i <= WAIT_CYCLES - 1; i++) begin
            @(negedge gameClk);
            sel    = (i == 5);
            cursor = 4'd2;
        end
        check_output("init_busy_17", 32'(busy), 32'd1);
        @(negedge gameClk);
        check_output("init_busy_18", 32'(busy), 32'd0);
        check_output("init_revealed", 32'(revealed), 32'd0);
        check_output("init_moves", 32'(moves), 32'd0);
    endtask

    task automatic reset_now(input string tag);
        #2 resetn = 1'b1;
        #1;
        check_output({tag, "_revealed"}, 32'(revealed), 32'd0);
        check_output({tag, "_matched"}, 32'(matched), 32'd0);
        check_output({tag, "_moves"}, 32'(moves), 32'd0);
        check_output({tag, "_ramWe"}, 32'(ramWe), 32'd0);
        check_output({tag, "_ramAddr"}, 32'(ramAddr), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        we_log.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge gameClk);
        check_output("rst_ramAddr", 32'(ramAddr), 32'd0);
        check_output("rst_ramWrite", 32'(ramWrite), 32'd0);
        check_output("rst_ramWe", 32'(ramWe), 32'd0);
        check_output("rst_gameOver", 32'(gameOver), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd1);
        release_and_init();

        // Mismatch 0/1: face-up through CAP2, CMP and four HOLD cycles.
        apply_stimulus(4'd0);
        wait_settle("mis_a");
        apply_stimulus(4'd1);
        repeat (6) @(negedge gameClk);
        check_output("hold_revealed_last", 32'(revealed), 32'h0003);
        check_output("hold_moves", 32'(moves), 32'd1);
        @(negedge gameClk);
        check_output("hidden_revealed", 32'(revealed), 32'h0000);
        check_output("hidden_busy", 32'(busy), 32'd0);
        check_output("mis_we_count", 32'(we_log.size()), 32'd0);

        // Match 2/3.
        play_pair(4'd2, 4'd3);
        check_output("match_revealed", 32'(revealed), 32'h000C);
        check_output("match_matched", 32'(matched), 32'h000C);
        check_output("match_pairs", 32'(pairs), 32'd1);
        check_output("match_moves", 32'(moves), 32'd2);
        check_output("match_we_count", 32'(we_log.size()), 32'd2);
        if (we_log.size() == 2) begin
            check_output("match_we_addr0", 32'(we_log[0]), 32'd2);
            check_output("match_we_addr1", 32'(we_log[1]), 32'd3);
        end
        check_output("match_mem2", 32'(mem[2]), 32'h00FF);
        check_output("match_mem3", 32'(mem[3]), 32'h00FF);

        // Ignored selects: matched tile in IDLE1, repeat tile and matched tile in IDLE2.
        apply_stimulus(4'd2);
        check_output("ign1_busy", 32'(busy), 32'd0);
        apply_stimulus(4'd0);
        wait_settle("ign_first");
        apply_stimulus(4'd0);
        apply_stimulus(4'd2);
        check_output("ign2_busy", 32'(busy), 32'd0);
        check_output("ign2_revealed", 32'(revealed), 32'h000D);
        check_output("ign2_moves", 32'(moves), 32'd2);
        apply_stimulus(4'd4);
        wait_settle("pair_0_4");

        play_pair(4'd1, 4'd5);
        play_pair(4'd6, 4'd7);
        play_pair(4'd8, 4'd9);
        play_pair(4'd10, 4'd11);
        play_pair(4'd12, 4'd13);
        play_pair(4'd14, 4'd15);
        check_output("done_pairs", 32'(pairs), 32'd8);
        check_output("done_gameOver", 32'(gameOver), 32'd1);
        check_output("done_matched", 32'(matched), 32'hFFFF);
        check_output("done_moves", 32'(moves), 32'd9);
        apply_stimulus(4'd1);
        apply_stimulus(4'd9);
        repeat (4) @(negedge gameClk);
        check_output("done_moves_after", 32'(moves), 32'd9);
        check_output("done_busy_after", 32'(busy), 32'd1);

        // Reset in HOLD.
        reset_now("rst_done");
        release_and_init();
        apply_stimulus(4'd0);
        wait_settle("hold_a");
        apply_stimulus(4'd1);
        repeat (4) @(negedge gameClk);
        check_output("pre_rst_hold_revealed", 32'(revealed), 32'h0003);
        reset_now("rst_hold");
        release_and_init();

        // Reset in WR2.
        apply_stimulus(4'd2);
        wait_settle("wr_a");
        apply_stimulus(4'd3);
        repeat (4) @(negedge gameClk);
        check_output("pre_rst_wr2_ramWe", 32'(ramWe), 32'd1);
        check_output("pre_rst_wr2_ramAddr", 32'(ramAddr), 32'd2);
        reset_now("rst_wr2");
        release_and_init();

        play_pair(4'd2, 4'd3);
        check_output("again_matched", 32'(matched), 32'h000C);
        check_output("again_pairs", 32'(pairs), 32'd1);
        check_output("again_moves", 32'(moves), 32'd1);
        check_output("again_we_count", 32'(we_log.size()), 32'd2);

        repeat (2) @(negedge gameClk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
